// File: rtl/keyboard_key_decoder_if.sv
// Scan-code byte stream into the key decoder and the per-key status it reports.
interface keyboard_key_decoder_if #(
    parameter int NUM_KEYS = 4
);
    logic [7:0]          rx_data;
    logic                rx_valid;
    logic [NUM_KEYS-1:0] held;
    logic [NUM_KEYS-1:0] pressed;
    logic [NUM_KEYS-1:0] released;
    logic [NUM_KEYS-1:0] repeat_pulse;
    logic                any_held;

    modport master (
        output rx_data, rx_valid,
        input  held, pressed, released, repeat_pulse, any_held
    );

    modport slave (
        input  rx_data, rx_valid,
        output held, pressed, released, repeat_pulse, any_held
    );
endinterface

// File: rtl/keyboard_key_decoder.sv
// PS/2 set-2 scan-code parser that tracks a table of keys, reports press/release
// edges and generates typematic repeat pulses for the most recently pressed key.
module keyboard_key_decoder #(
    parameter int                    NUM_KEYS       = 4,
    parameter logic [NUM_KEYS*8-1:0] KEY_CODES      = {8'h72, 8'h75, 8'h5A, 8'h29},
    parameter logic [NUM_KEYS-1:0]   KEY_EXT        = 4'b1100,
    parameter int                    REPEAT_DELAY   = 25_000_000,
    parameter int                    REPEAT_PERIOD  = 5_000_000,
    parameter int                    PREFIX_TIMEOUT = 65_535
) (
    input  logic                  clk,
    input  logic                  rst_n,
    keyboard_key_decoder_if.slave kbd
);
    localparam int         REP_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int         REP_W    = $clog2(REP_MAX + 1);
    localparam int         TO_W     = $clog2(PREFIX_TIMEOUT + 1);
    localparam int         IDX_W    = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam logic [7:0] BYTE_EXT = 8'hE0;
    localparam logic [7:0] BYTE_BRK = 8'hF0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [TO_W-1:0]     r_to_cnt;
    logic                w_evt;
    logic                w_evt_make;
    logic                w_evt_ext;

    logic [NUM_KEYS-1:0] r_held;
    logic [NUM_KEYS-1:0] r_pressed;
    logic [NUM_KEYS-1:0] r_released;
    logic [NUM_KEYS-1:0] r_rep_pulse;
    logic [NUM_KEYS-1:0] w_hit;
    logic [NUM_KEYS-1:0] w_make_new;
    logic [NUM_KEYS-1:0] w_brk_new;
    logic                w_new_press;
    logic [IDX_W-1:0]    w_new_idx;

    logic                r_rep_arm;
    logic [IDX_W-1:0]    r_rep_idx;
    logic [REP_W-1:0]    r_rep_cnt;
    logic                w_rep_stop;

    function automatic logic key_match(input logic [7:0] code, input logic ext, input int idx);
        return (code == KEY_CODES[8*idx +: 8]) && (ext == KEY_EXT[idx]);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A complete code emits one event in the same cycle its final byte arrives.
    always_comb begin
        w_state_nxt = r_state;
        w_evt       = 1'b0;
        w_evt_make  = 1'b0;
        w_evt_ext   = 1'b0;
        if (kbd.rx_valid) begin
            case (r_state)
                S_IDLE: begin
                    if (kbd.rx_data == BYTE_EXT) begin
                        w_state_nxt = S_EXT;
                    end else if (kbd.rx_data == BYTE_BRK) begin
                        w_state_nxt = S_BRK;
                    end else begin
                        w_evt      = 1'b1;
                        w_evt_make = 1'b1;
                    end
                end
                S_EXT: begin
                    if (kbd.rx_data == BYTE_BRK) begin
                        w_state_nxt = S_EXT_BRK;
                    end else if (kbd.rx_data != BYTE_EXT) begin
                        w_evt       = 1'b1;
                        w_evt_make  = 1'b1;
                        w_evt_ext   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_BRK: begin
                    w_evt       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                S_EXT_BRK: begin
                    w_evt       = 1'b1;
                    w_evt_ext   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end else if ((r_state != S_IDLE) && (r_to_cnt == TO_W'(PREFIX_TIMEOUT - 1))) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Counts idle cycles spent waiting inside a prefix; any byte restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (kbd.rx_valid || (w_state_nxt == S_IDLE)) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    always_comb begin
        w_hit       = '0;
        w_make_new  = '0;
        w_brk_new   = '0;
        w_new_press = 1'b0;
        w_new_idx   = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            w_hit[i]      = w_evt && key_match(kbd.rx_data, w_evt_ext, i);
            w_make_new[i] = w_hit[i] && w_evt_make && !r_held[i];
            w_brk_new[i]  = w_hit[i] && !w_evt_make && r_held[i];
            if (w_make_new[i]) begin
                w_new_press = 1'b1;
                w_new_idx   = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_held     <= '0;
            r_pressed  <= '0;
            r_released <= '0;
        end else begin
            r_held     <= (r_held | w_make_new) & ~w_brk_new;
            r_pressed  <= w_make_new;
            r_released <= w_brk_new;
        end
    end

    assign w_rep_stop = r_rep_arm && w_brk_new[r_rep_idx];

    // Down-counter: loaded with delay-1 on press, fires at zero, reloads period-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rep_arm   <= 1'b0;
            r_rep_idx   <= '0;
            r_rep_cnt   <= '0;
            r_rep_pulse <= '0;
        end else begin
            r_rep_pulse <= '0;
            if (w_new_press) begin
                r_rep_arm <= 1'b1;
                r_rep_idx <= w_new_idx;
                r_rep_cnt <= REP_W'(REPEAT_DELAY - 1);
            end else if (w_rep_stop) begin
                r_rep_arm <= 1'b0;
                r_rep_cnt <= '0;
            end else if (r_rep_arm && r_held[r_rep_idx]) begin
                if (r_rep_cnt == '0) begin
                    r_rep_pulse[r_rep_idx] <= 1'b1;
                    r_rep_cnt              <= REP_W'(REPEAT_PERIOD - 1);
                end else begin
                    r_rep_cnt <= r_rep_cnt - 1'b1;
                end
            end
        end
    end

    assign kbd.held         = r_held;
    assign kbd.pressed      = r_pressed;
    assign kbd.released     = r_released;
    assign kbd.repeat_pulse = r_rep_pulse;
    assign kbd.any_held     = |r_held;

endmodule

// File: tb/tb_keyboard_key_decoder.sv
// Directed bench for keyboard_key_decoder with a prefix-flag key model checked every cycle.
module tb_keyboard_key_decoder;
    localparam int T_OUT = 20;
    localparam int DLY   = 10;
    localparam int PER   = 4;
    localparam logic [7:0] K_CODE [4] = '{8'h29, 8'h5A, 8'h75, 8'h72};
    localparam bit         K_EXT  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    keyboard_key_decoder_if #(.NUM_KEYS(4)) kbd ();

    keyboard_key_decoder #(
        .NUM_KEYS      (4),
        .KEY_CODES     (32'h72755A29),
        .KEY_EXT       (4'b1100),
        .REPEAT_DELAY  (DLY),
        .REPEAT_PERIOD (PER),
        .PREFIX_TIMEOUT(T_OUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .kbd  (kbd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: prefix flags, held set, and an absolute-cycle schedule for repeats.
    bit       m_ext, m_brk, m_arm;
    bit [3:0] m_held, m_pressed, m_released, m_rep;
    int       m_idle, m_cyc, m_rep_key, m_next;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ext = 0; m_brk = 0; m_arm = 0;
            m_held = 0; m_pressed = 0; m_released = 0; m_rep = 0;
            m_idle = 0; m_cyc = 0; m_rep_key = 0; m_next = 0;
        end else begin
            bit new_press;
            new_press  = 0;
            m_cyc      = m_cyc + 1;
            m_pressed  = 0;
            m_released = 0;
            m_rep      = 0;
            if (kbd.rx_valid) begin
                m_idle = 0;
                if (!m_brk && kbd.rx_data == 8'hE0) m_ext = 1;
                else if (!m_brk && kbd.rx_data == 8'hF0) m_brk = 1;
                else begin
                    for (int k = 0; k < 4; k++) begin
                        if (K_CODE[k] == kbd.rx_data && K_EXT[k] == m_ext) begin
                            if (!m_brk && !m_held[k]) begin
                                m_held[k] = 1; m_pressed[k] = 1; new_press = 1;
                                m_arm = 1; m_rep_key = k; m_next = m_cyc + DLY;
                            end else if (m_brk && m_held[k]) begin
                                m_held[k] = 0; m_released[k] = 1;
                                if (m_arm && m_rep_key == k) m_arm = 0;
                            end
                        end
                    end
                    m_ext = 0;
                    m_brk = 0;
                end
            end else begin
                m_idle = m_idle + 1;
                if ((m_ext || m_brk) && m_idle >= T_OUT) begin
                    m_ext = 0;
                    m_brk = 0;
                end
            end
            if (m_arm && !new_press && m_cyc == m_next) begin
                m_rep[m_rep_key] = 1;
                m_next = m_next + PER;
            end
        end
    end

    // Every-cycle comparison of DUT against model.
    always @(negedge clk) begin
        n_checks += 5;
        if (kbd.held !== m_held) begin
            n_fail++; $display("FAIL held @%0t: got %b expected %b", $time, kbd.held, m_held);
        end
        if (kbd.pressed !== m_pressed) begin
            n_fail++; $display("FAIL pressed @%0t: got %b expected %b", $time, kbd.pressed, m_pressed);
        end
        if (kbd.released !== m_released) begin
            n_fail++; $display("FAIL released @%0t: got %b expected %b", $time, kbd.released, m_released);
        end
        if (kbd.repeat_pulse !== m_rep) begin
            n_fail++; $display("FAIL repeat_pulse @%0t: got %b expected %b", $time, kbd.repeat_pulse, m_rep);
        end
        if (kbd.any_held !== (|m_held)) begin
            n_fail++; $display("FAIL any_held @%0t: got %b expected %b", $time, kbd.any_held, |m_held);
        end
    end

    // Repeat timing relative to the pulse of the key's press, for literal checks.
    int ncyc = 0;
    int press_cyc [4];
    int rel1 [$];
    int rel3 [$];
    int rep0_cnt   = 0;
    int press1_cnt = 0;

    always @(negedge clk) begin
        ncyc++;
        for (int k = 0; k < 4; k++) if (kbd.pressed[k] === 1'b1) press_cyc[k] = ncyc;
        if (kbd.repeat_pulse[1] === 1'b1) rel1.push_back(ncyc - press_cyc[1]);
        if (kbd.repeat_pulse[3] === 1'b1) rel3.push_back(ncyc - press_cyc[3]);
        if (kbd.repeat_pulse[0] === 1'b1) rep0_cnt++;
        if (kbd.pressed[1] === 1'b1) press1_cnt++;
    end

    task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        kbd.rx_data  = b;
        kbd.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        kbd.rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        kbd.rx_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        kbd.rx_data  = 8'h00;
        kbd.rx_valid = 1'b0;
        rst_n        = 1'b1;
        #1 rst_n     = 1'b0;
        idle(3);
        check_lit("reset_held", kbd.held, 4'b0000);
        check_lit("reset_any_held", kbd.any_held, 1'b0);
        rst_n = 1'b1;
        idle(2);

        // Plain key: make then break.
        send(8'h29);
        check_lit("space_pressed", kbd.pressed, 4'b0001);
        check_lit("space_held", kbd.held, 4'b0001);
        check_lit("model_space_held", m_held, 4'b0001);
        send(8'hF0); send(8'h29);
        check_lit("space_released", kbd.released, 4'b0001);
        check_lit("space_held_off", kbd.held, 4'b0000);

        // Extended key; bare code must not match.
        send(8'hE0); send(8'h75);
        check_lit("up_held", kbd.held, 4'b0100);
        send(8'h75);
        check_lit("bare75_held", kbd.held, 4'b0100);
        check_lit("bare75_pressed", kbd.pressed, 4'b0000);
        send(8'hE0); send(8'hF0); send(8'h75);
        check_lit("up_released", kbd.released, 4'b0100);
        check_lit("up_held_off", kbd.held, 4'b0000);

        // Keyboard typematic makes and the repeat schedule.
        idle(2);
        press1_cnt = 0;
        rel1.delete();
        send(8'h5A); send(8'h5A); send(8'h5A);
        idle(15);
        send(8'hF0); send(8'h5A);
        idle(10);
        check_lit("enter_press_count", press1_cnt, 1);
        check_lit("enter_rep_count", rel1.size(), 3);
        check_lit("enter_rep0", rel1.size() > 0 ? rel1[0] : -1, 10);
        check_lit("enter_rep1", rel1.size() > 1 ? rel1[1] : -1, 14);
        check_lit("enter_rep2", rel1.size() > 2 ? rel1[2] : -1, 18);
        check_lit("enter_held_off", kbd.held, 4'b0000);

        // Newer press takes over the repeat; release of the older key leaves it alone.
        rel3.delete();
        rep0_cnt = 0;
        send(8'h29); send(8'hE0); send(8'h72);
        check_lit("two_held", kbd.held, 4'b1001);
        check_lit("model_two_held", m_held, 4'b1001);
        idle(3);
        send(8'hF0); send(8'h29);
        check_lit("down_only_held", kbd.held, 4'b1000);
        idle(12);
        check_lit("down_rep_count", rel3.size(), 2);
        check_lit("down_rep0", rel3.size() > 0 ? rel3[0] : -1, 10);
        check_lit("down_rep1", rel3.size() > 1 ? rel3[1] : -1, 14);
        check_lit("space_no_repeat", rep0_cnt, 0);
        send(8'hE0); send(8'hF0); send(8'h72);
        check_lit("down_held_off", kbd.held, 4'b0000);
        idle(4);

        // Prefix timeout: exactly the limit returns to idle, one short does not.
        send(8'hF0);
        idle(T_OUT);
        send(8'h29);
        check_lit("timeout_make", kbd.pressed, 4'b0001);
        send(8'hF0); send(8'h29);
        send(8'hF0);
        idle(T_OUT - 1);
        send(8'h29);
        check_lit("short_wait_pressed", kbd.pressed, 4'b0000);
        check_lit("short_wait_held", kbd.held, 4'b0000);
        send(8'h29);
        check_lit("after_short_make", kbd.pressed, 4'b0001);
        send(8'hF0); send(8'h29);
        send(8'hE0);
        idle(T_OUT);
        send(8'h75);
        check_lit("ext_timeout_held", kbd.held, 4'b0000);

        // Reset in the middle of an extended break.
        send(8'hE0); send(8'h75);
        check_lit("pre_reset_held", kbd.held, 4'b0100);
        send(8'hE0); send(8'hF0);
        rst_n = 1'b0;
        #2;
        check_lit("mid_reset_held", kbd.held, 4'b0000);
        check_lit("mid_reset_any", kbd.any_held, 1'b0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        send(8'h75);
        check_lit("post_reset_held", kbd.held, 4'b0000);
        check_lit("post_reset_released", kbd.released, 4'b0000);
        send(8'hE0); send(8'h75);
        check_lit("post_reset_up", kbd.held, 4'b0100);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/keyboard_key_decoder.md
KEYBOARD_KEY_DECODER -- requirements
Module: keyboard_key_decoder

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 4: number of tracked keys, 1..16.
REQ-002 SHALL have parameter KEY_CODES, default {8'h72,8'h75,8'h5A,8'h29}: NUM_KEYS*8 bits of scan codes, key i at bits [8i+7:8i]; key0 = space (29), key1 = enter (5A), key2 = up (E0 75), key3 = down (E0 72).
REQ-003 SHALL have parameter KEY_EXT, default 4'b1100: bit i set means key i needs the E0 prefix.
REQ-004 SHALL have parameter REPEAT_DELAY, default 25_000_000: cycles from press to first repeat pulse.
REQ-005 SHALL have parameter REPEAT_PERIOD, default 5_000_000: cycles between later repeat pulses.
REQ-006 SHALL have parameter PREFIX_TIMEOUT, default 65_535: cycles a prefix state may wait for its next byte.
REQ-007 clk  input  1  system clock; all state changes on its rising edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 rx_data  input  8  scan-code byte from the PS/2 receiver.
REQ-010 rx_valid  input  1  one-cycle strobe; rx_data is valid in that cycle.
REQ-011 held  output  NUM_KEYS  level; bit i is 1 while key i is held down.
REQ-012 pressed  output  NUM_KEYS  one-cycle pulse when key i goes from released to held.
REQ-013 released  output  NUM_KEYS  one-cycle pulse when key i goes from held to released.
REQ-014 repeat_pulse  output  NUM_KEYS  one-cycle typematic pulse, at most one bit set at a time.
REQ-015 any_held  output  1  OR of held.

Function
REQ-016 Parser FSM SHALL have states IDLE, EXT, BRK, EXT_BRK; it advances only on cycles with rx_valid=1.
REQ-017 From IDLE: byte E0 -> EXT; F0 -> BRK; any other byte -> make event (ext=0), stay in IDLE.
REQ-018 From EXT: F0 -> EXT_BRK; E0 -> stay in EXT; any other byte -> make event (ext=1), go to IDLE.
REQ-019 From BRK: any byte -> break event (ext=0), go to IDLE. From EXT_BRK: any byte -> break event (ext=1), go to IDLE.
REQ-020 An event matches key i only when code == KEY_CODES[i] and ext == KEY_EXT[i]. Unmatched events change nothing.
REQ-021 Make on a released key: held[i]<=1 and pressed[i]=1 for one cycle. Make on a held key (keyboard typematic): no pulse, no change.
REQ-022 Break on a held key: held[i]<=0 and released[i]=1 for one cycle. Break on a released key: no effect.
REQ-023 Outputs SHALL be registered: all three of held, pressed and released update in the cycle after the rx_valid that carries the final byte.
REQ-024 In EXT, BRK or EXT_BRK, PREFIX_TIMEOUT consecutive cycles with no rx_valid SHALL return the FSM to IDLE without an event; the timeout counter clears on every rx_valid.
REQ-025 Repeat generator tracks one key, the most recently pressed (rep_idx), with a counter sized $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1).
REQ-026 On any pressed pulse: rep_idx <= that key, counter restarts, next target = REPEAT_DELAY.
REQ-027 While held[rep_idx]=1: counter reaching its target pulses repeat_pulse[rep_idx] for one cycle, then reloads with target REPEAT_PERIOD.
REQ-028 Release of the tracked key SHALL stop and disarm the generator; release of any other key SHALL not affect it.
REQ-029 rx_valid in every cycle SHALL be accepted with no stalls and no dropped bytes.

Reset
REQ-030 While rst_n=0: FSM=IDLE; held, pressed, released, repeat_pulse all 0; any_held=0; counters 0; generator disarmed.
REQ-031 Reset mid-sequence (e.g. after E0 F0) SHALL discard the partial code; the first byte after reset is parsed from IDLE.

Verification
REQ-032 Bytes 29 -> pressed[0] pulses, held=0001; then F0,29 -> released[0] pulses, held=0000.
REQ-033 Bytes E0,75 -> held[2]=1. Bare 75 (no E0) -> no change. E0,F0,75 -> released[2] pulses.
REQ-034 Bytes 5A,5A,5A -> exactly one pressed[1] pulse. Hold with REPEAT_DELAY=10, REPEAT_PERIOD=4 -> repeat_pulse[1] at +10, +14, +18 cycles; stops after F0,5A.
REQ-035 Press 29 then E0,72 while 29 is still held -> held=1001, repeat tracks key3. Release 29 -> repeat continues on key3.
REQ-036 Byte F0 then idle for PREFIX_TIMEOUT cycles, then 29 -> treated as a make: pressed[0] pulses.
REQ-037 rst_n pulsed low after E0,F0 while key2 is held -> all outputs 0. Then byte 75 -> no event (unmatched non-extended code).
